// File: rtl/dsram_access_ctrl_if.sv
//============================================================================
// Module      : dsram_access_ctrl_if
// Description : Data-SRAM-like bus (req / addr_ok / data_ok split handshake)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface dsram_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

`default_nettype wire

// File: rtl/dsram_access_ctrl.sv
//============================================================================
// Module      : dsram_access_ctrl
// Description : MEM-stage load/store sequencer for the data-SRAM-like bus.
//               Optional data_ok watchdog enabled by macro DSRAM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module dsram_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  wire                 clk,
    input  wire                 resetn,
    input  wire                 ms_valid,
    input  wire  [7:0]          mem_control,
    input  wire  [31:0]         addr,
    input  wire  [31:0]         wdata,
    input  wire  [6:0]          except_in,
    input  wire                 flush,
    input  wire                 ws_allowin,
    dsram_access_ctrl_if.master bus,
    output logic                ms_stall,
    output logic [31:0]         rdata_raw,
    output logic                acc_done,
    output logic                bus_err
);

    // mem_control encodings shared with the decode stage
    localparam logic [7:0] c_mem_lb  = 8'h01;
    localparam logic [7:0] c_mem_lbu = 8'h02;
    localparam logic [7:0] c_mem_lh  = 8'h04;
    localparam logic [7:0] c_mem_lhu = 8'h08;
    localparam logic [7:0] c_mem_lw  = 8'h10;
    localparam logic [7:0] c_mem_sb  = 8'h20;
    localparam logic [7:0] c_mem_sh  = 8'h40;
    localparam logic [7:0] c_mem_sw  = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_acc;
    logic        w_wr;
    logic [1:0]  w_size;
    logic [3:0]  w_strb_sz;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic        w_go;

    logic        w_capture;
    logic        w_req_clr;
    logic        w_complete;
    logic        w_done_clr;
    logic        w_tmo_fire;
    logic        w_busy;

    logic        r_data_req;
    logic        r_data_wr;
    logic [1:0]  r_data_size;
    logic [31:0] r_data_addr;
    logic [3:0]  r_data_wstrb;
    logic [31:0] r_data_wdata;
    logic [31:0] r_rdata_raw;
    logic        r_acc_done;

    always_comb begin
        w_acc  = 1'b1;
        w_wr   = 1'b0;
        w_size = 2'd0;
        case (mem_control)
            c_mem_lb, c_mem_lbu: w_size = 2'd0;
            c_mem_lh, c_mem_lhu: w_size = 2'd1;
            c_mem_lw:            w_size = 2'd2;
            c_mem_sb: begin w_wr = 1'b1; w_size = 2'd0; end
            c_mem_sh: begin w_wr = 1'b1; w_size = 2'd1; end
            c_mem_sw: begin w_wr = 1'b1; w_size = 2'd2; end
            default:             w_acc  = 1'b0;
        endcase
    end

    // Lane replication lets the slave pick the bytes by strobe alone
    always_comb begin
        w_strb_sz = 4'b1111;
        w_wdata   = wdata;
        case (w_size)
            2'd0: begin
                w_strb_sz = 4'b0001 << addr[1:0];
                w_wdata   = {4{wdata[7:0]}};
            end
            2'd1: begin
                w_strb_sz = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{wdata[15:0]}};
            end
            default: begin
                w_strb_sz = 4'b1111;
                w_wdata   = wdata;
            end
        endcase
        w_wstrb = w_wr ? w_strb_sz : 4'b0000;
    end

    assign w_go   = ms_valid & w_acc & ~(|except_in) & ~flush;
    assign w_busy = (r_state == S_REQ) | (r_state == S_WAIT) | (r_state == S_DRAIN);

`ifdef DSRAM_TIMEOUT_EN
    localparam int unsigned c_tmo_w = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC) : 8;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);
    logic [c_tmo_w-1:0] r_tmo_cnt;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ms_stall    = 1'b0;
        w_capture   = 1'b0;
        w_req_clr   = 1'b0;
        w_complete  = 1'b0;
        w_done_clr  = 1'b0;
        w_tmo_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ms_stall   = w_go;
                w_done_clr = 1'b1;
                if (w_go) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                ms_stall = 1'b1;
                if (bus.data_addr_ok) begin
                    w_req_clr   = 1'b1;
                    w_state_nxt = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    w_req_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                ms_stall = 1'b1;
                if (bus.data_data_ok) begin
                    ms_stall = ~ws_allowin;
                    // A flush landing on the response cycle has nothing left to drain
                    if (flush) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_complete  = 1'b1;
                        w_state_nxt = ws_allowin ? S_IDLE : S_HOLD;
                    end
                end else if (flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_HOLD: begin
                ms_stall = ~ws_allowin;
                if (ws_allowin || flush) begin
                    w_done_clr  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.data_data_ok) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef DSRAM_TIMEOUT_EN
        if (w_busy && (r_tmo_cnt == c_tmo_last) && (w_state_nxt == r_state)) begin
            w_tmo_fire  = 1'b1;
            w_req_clr   = 1'b1;
            w_state_nxt = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_req   <= 1'b0;
            r_data_wr    <= 1'b0;
            r_data_size  <= 2'd0;
            r_data_addr  <= 32'd0;
            r_data_wstrb <= 4'd0;
            r_data_wdata <= 32'd0;
            r_rdata_raw  <= 32'd0;
            r_acc_done   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data_req   <= 1'b1;
                r_data_wr    <= w_wr;
                r_data_size  <= w_size;
                r_data_addr  <= addr;
                r_data_wstrb <= w_wstrb;
                r_data_wdata <= w_wdata;
            end else if (w_req_clr) begin
                r_data_req   <= 1'b0;
            end

            if (w_complete && !r_data_wr) begin
                r_rdata_raw <= bus.data_rdata;
            end else if (w_tmo_fire) begin
                r_rdata_raw <= 32'd0;
            end

            if (w_complete || w_tmo_fire) begin
                r_acc_done <= 1'b1;
            end else if (w_done_clr) begin
                r_acc_done <= 1'b0;
            end
        end
    end

`ifdef DSRAM_TIMEOUT_EN
    logic r_bus_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= r_bus_err | w_tmo_fire;
            if (!w_busy || (w_state_nxt != r_state)) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign bus_err = r_bus_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYC;
    assign bus_err      = 1'b0;
`endif

    assign bus.data_req   = r_data_req;
    assign bus.data_wr    = r_data_wr;
    assign bus.data_size  = r_data_size;
    assign bus.data_addr  = r_data_addr;
    assign bus.data_wstrb = r_data_wstrb;
    assign bus.data_wdata = r_data_wdata;
    assign rdata_raw      = r_rdata_raw;
    assign acc_done       = r_acc_done;

endmodule

`default_nettype wire
